// File: rtl/comm_pkg.sv
// Definitions shared by the result writer: FSM states, BRAM byte-enable width, default base address.
package comm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECTING,
        ST_FINISHING
    } wr_state_t;

    localparam int BRAM_BE_W = 4;
    localparam logic [31:0] RESULT_BASE_ADDR = 32'hB000_1000;

    // Byte enables for a word filled from byte lane 0 up to and including last_idx (big-endian lanes).
    function automatic logic [BRAM_BE_W-1:0] fill_mask(input logic [1:0] last_idx);
        logic [BRAM_BE_W-1:0] ones;
        ones = {BRAM_BE_W{1'b1}};
        fill_mask = ~(ones >> (3'(last_idx) + 3'd1));
    endfunction

endpackage

// File: rtl/result_packer.sv
// Converts a signed filter result to a pixel and merges it into a big-endian word lane.
// WRITE_MODULE_SATURATE_EN selects clamping to [0, 2^PIXEL_SIZE-1]; otherwise low bits are kept.
module result_packer
    import comm_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PIXEL_SIZE   = 8,
    parameter int RESULT_WIDTH = 16
) (
    input  logic signed [RESULT_WIDTH-1:0] result,
    input  logic        [1:0]              byte_idx,
    input  logic        [DATA_WIDTH-1:0]   word_in,
    output logic        [DATA_WIDTH-1:0]   word_out
);

    localparam int LANE_W  = DATA_WIDTH / BRAM_BE_W;
    localparam int PIX_MAX = (1 << PIXEL_SIZE) - 1;

`ifdef WRITE_MODULE_SATURATE_EN
    function automatic logic [PIXEL_SIZE-1:0] to_pixel(input logic signed [RESULT_WIDTH-1:0] r);
        if (r < 0)
            to_pixel = '0;
        else if (r > PIX_MAX)
            to_pixel = '1;
        else
            to_pixel = r[PIXEL_SIZE-1:0];
    endfunction
`else
    function automatic logic [PIXEL_SIZE-1:0] to_pixel(input logic signed [RESULT_WIDTH-1:0] r);
        to_pixel = r[PIXEL_SIZE-1:0];
    endfunction
`endif

    logic [DATA_WIDTH-1:0] lane;
    int                    shift;

    always_comb begin
        lane     = DATA_WIDTH'(to_pixel(result));
        shift    = LANE_W * ((BRAM_BE_W - 1) - int'(byte_idx));
        word_out = word_in | (lane << shift);
    end

endmodule

// File: rtl/write_module.sv
// Collects filter results into packed words and writes each image word-aligned into BRAM.
// Optional build macro WRITE_MODULE_SATURATE_EN enables pixel saturation in result_packer.
module write_module
    import comm_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] RESULT_ADDR    = RESULT_BASE_ADDR,
    parameter int          PIXEL_SIZE     = 8,
    parameter int          RESULT_WIDTH   = 16,
    parameter int          OUT_IMAGE_SIZE = 676,
    parameter int          TOT_NUM_IMAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write_result,
    input  logic signed [RESULT_WIDTH-1:0] result,
    input  logic                           result_valid,
    output logic        [ADDR_WIDTH-1:0]   bram_addr,
    output logic        [DATA_WIDTH-1:0]   bram_wrdata,
    output logic                           bram_en,
    output logic        [BRAM_BE_W-1:0]    bram_we,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam int PIX_CNT_W = $clog2(OUT_IMAGE_SIZE + 1);
    localparam int IMG_CNT_W = $clog2(TOT_NUM_IMAGES + 1);

    wr_state_t              state, state_nxt;
    logic                   prev_write_result;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [DATA_WIDTH-1:0]  word_acc;
    logic [DATA_WIDTH-1:0]  word_packed;
    logic [1:0]             byte_idx;
    logic [PIX_CNT_W-1:0]   pix_cnt;
    logic [IMG_CNT_W-1:0]   img_cnt;
    logic                   arm_edge;
    logic                   accept;
    logic                   last_pix;
    logic                   last_img;
    logic                   flush;

    assign arm_edge = write_result && !prev_write_result;
    assign accept   = (state == ST_COLLECTING) && result_valid;
    assign last_pix = (pix_cnt == PIX_CNT_W'(OUT_IMAGE_SIZE - 1));
    assign last_img = (img_cnt == IMG_CNT_W'(TOT_NUM_IMAGES - 1));
    assign flush    = accept && ((byte_idx == 2'd3) || last_pix);
    assign busy     = (state != ST_IDLE);

    result_packer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PIXEL_SIZE  (PIXEL_SIZE),
        .RESULT_WIDTH(RESULT_WIDTH)
    ) u_packer (
        .result  (result),
        .byte_idx(byte_idx),
        .word_in (word_acc),
        .word_out(word_packed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (arm_edge) state_nxt = ST_COLLECTING;
            ST_COLLECTING: if (accept && last_pix && last_img) state_nxt = ST_FINISHING;
            ST_FINISHING:  state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // Write stage: a word completed on this edge is presented to the BRAM during the next cycle,
    // while the accumulator is already free to take the following pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_write_result <= 1'b0;
            wr_ptr            <= '0;
            word_acc          <= '0;
            byte_idx          <= '0;
            pix_cnt           <= '0;
            img_cnt           <= '0;
            bram_addr         <= '0;
            bram_wrdata       <= '0;
            bram_en           <= 1'b0;
            bram_we           <= '0;
            done              <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            prev_write_result <= write_result;
            done              <= (state == ST_FINISHING);
            bram_en           <= flush;
            bram_we           <= flush ? fill_mask(byte_idx) : '0;

            if (flush) begin
                bram_addr   <= wr_ptr;
                bram_wrdata <= word_packed;
                wr_ptr      <= wr_ptr + ADDR_WIDTH'(4);
                word_acc    <= '0;
                byte_idx    <= '0;
            end else if (accept) begin
                word_acc    <= word_packed;
                byte_idx    <= byte_idx + 2'd1;
            end

            if (accept) begin
                if (last_pix) begin
                    pix_cnt <= '0;
                    img_cnt <= last_img ? '0 : img_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end

            if ((state == ST_IDLE) && arm_edge) begin
                wr_ptr   <= ADDR_WIDTH'(RESULT_ADDR);
                word_acc <= '0;
                byte_idx <= '0;
                pix_cnt  <= '0;
                img_cnt  <= '0;
                overrun  <= 1'b0;
            end else if (result_valid && (state != ST_COLLECTING)) begin
                overrun  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_module.sv
// Table-driven bench for write_module (6-pixel images, 2 per batch) with a BRAM write scoreboard.
module tb_write_module;

    localparam logic [31:0] BASE = 32'hB000_1000;
    localparam int IMG_SZ = 6;
    localparam int N_IMG  = 2;
    localparam int N_PIX  = IMG_SZ * N_IMG;

    typedef struct {
        logic signed [15:0] res;
        logic [7:0]         sat;
        logic [7:0]         trunc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } exp_wr_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               write_result = 1'b0;
    logic signed [15:0] result = '0;
    logic               result_valid = 1'b0;
    logic [31:0]        bram_addr;
    logic [31:0]        bram_wrdata;
    logic               bram_en;
    logic [3:0]         bram_we;
    logic               busy;
    logic               done;
    logic               overrun;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      last_wr_cyc = -10;
    int      done_cnt = 0;
    logic    prev_done = 1'b0;
    exp_wr_t exp_q[$];
    vec_t    tbl[N_PIX];

    logic [31:0] m_ptr;
    logic [31:0] m_word;
    int          m_idx;

    write_module #(
        .OUT_IMAGE_SIZE(IMG_SZ),
        .TOT_NUM_IMAGES(N_IMG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_result(write_result),
        .result      (result),
        .result_valid(result_valid),
        .bram_addr   (bram_addr),
        .bram_wrdata (bram_wrdata),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v);
`ifdef WRITE_MODULE_SATURATE_EN
        exp_byte = v.sat;
`else
        exp_byte = v.trunc;
`endif
    endfunction

    task automatic monitor();
        exp_wr_t e;
        cyc++;
        if (exp_q.size() == 0) begin
            chk("spurious_write", {59'd0, bram_en, bram_we}, 64'd0);
        end else if (bram_en) begin
            e = exp_q.pop_front();
            chk("wr_addr", bram_addr, e.addr);
            chk("wr_data", bram_wrdata, e.data);
            chk("wr_we", bram_we, e.we);
        end else begin
            chk("we_without_en", bram_we, 4'h0);
        end
        if (bram_en) last_wr_cyc = cyc;
        if (done) begin
            chk("done_after_last_write", cyc, last_wr_cyc + 1);
            chk("done_single_cycle", prev_done, 1'b0);
            chk("done_queue_drained", exp_q.size(), 0);
            done_cnt++;
        end
        prev_done = done;
    endtask

    // One clock: check outputs on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        write_result = 1'b0;
        tick();
        write_result = 1'b1;
        tick();
        chk("busy_after_arm", busy, 1'b1);
        m_ptr  = BASE;
        m_word = '0;
        m_idx  = 0;
    endtask

    task automatic drive_pix(input logic signed [15:0] r, input logic [7:0] b, input bit last, input bit gap);
        logic [3:0] mask;
        m_word = m_word | (32'(b) << (8 * (3 - m_idx)));
        m_idx++;
        if (m_idx == 4 || last) begin
            mask = 4'hF << (4 - m_idx);
            exp_q.push_back('{addr: m_ptr, data: m_word, we: mask});
            m_ptr  = m_ptr + 32'd4;
            m_word = '0;
            m_idx  = 0;
        end
        result       = r;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic wait_done();
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < 50 && done_cnt < target; i++) tick();
        chk("done_seen", done_cnt, target);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic run_table(input bit gap, input bit rearm_glitch);
        do_arm();
        for (int k = 0; k < N_PIX; k++) begin
            if (rearm_glitch && k == 4) write_result = 1'b0;
            if (rearm_glitch && k == 6) write_result = 1'b1;
            drive_pix(tbl[k].res, exp_byte(tbl[k]), (k % IMG_SZ) == IMG_SZ - 1, gap);
        end
        wait_done();
    endtask

    task automatic run_ramp_pixels();
        vec_t v;
        for (int k = 0; k < N_PIX; k++) begin
            v.res = 16'(k); v.sat = 8'(k); v.trunc = 8'(k);
            drive_pix(v.res, exp_byte(v), (k % IMG_SZ) == IMG_SZ - 1, 1'b0);
        end
        wait_done();
    endtask

    initial begin
        tbl[0]  = '{res: -16'sd5,    sat: 8'h00, trunc: 8'hFB};
        tbl[1]  = '{res: 16'sd300,   sat: 8'hFF, trunc: 8'h2C};
        tbl[2]  = '{res: 16'sd0,     sat: 8'h00, trunc: 8'h00};
        tbl[3]  = '{res: 16'sd255,   sat: 8'hFF, trunc: 8'hFF};
        tbl[4]  = '{res: 16'sd256,   sat: 8'hFF, trunc: 8'h00};
        tbl[5]  = '{res: 16'sd1,     sat: 8'h01, trunc: 8'h01};
        tbl[6]  = '{res: 16'sd127,   sat: 8'h7F, trunc: 8'h7F};
        tbl[7]  = '{res: -16'sd1,    sat: 8'h00, trunc: 8'hFF};
        tbl[8]  = '{res: 16'sd128,   sat: 8'h80, trunc: 8'h80};
        tbl[9]  = '{res: -16'sd32768, sat: 8'h00, trunc: 8'h00};
        tbl[10] = '{res: 16'sd32767, sat: 8'hFF, trunc: 8'hFF};
        tbl[11] = '{res: 16'sd2,     sat: 8'h02, trunc: 8'h02};

        tick();
        tick();
        chk("rst_addr", bram_addr, 32'd0);
        chk("rst_wrdata", bram_wrdata, 32'd0);
        chk("rst_en", bram_en, 1'b0);
        chk("rst_we", bram_we, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        tick();

        // Continuous stream, then the same data gapped with an ignored re-arm edge mid-batch.
        run_table(1'b0, 1'b0);
        run_table(1'b1, 1'b1);

        // Valid while idle: no write, sticky overrun until the next arming edge.
        write_result = 1'b0;
        tick();
        result       = 16'sd7;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        tick();
        chk("overrun_set", overrun, 1'b1);
        tick();
        chk("overrun_sticky", overrun, 1'b1);
        do_arm();
        chk("overrun_cleared", overrun, 1'b0);
        run_ramp_pixels();

        // Reset after three bytes of a word: nothing written, restart at base.
        do_arm();
        for (int k = 0; k < 3; k++) drive_pix(16'(k + 40), 8'(k + 40), 1'b0, 1'b0);
        write_result = 1'b0;
        reset = 1'b1;
        #2;
        chk("abort_en", bram_en, 1'b0);
        chk("abort_we", bram_we, 4'h0);
        chk("abort_addr", bram_addr, 32'd0);
        chk("abort_wrdata", bram_wrdata, 32'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_overrun", overrun, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        do_arm();
        run_ramp_pixels();

        tick();
        chk("queue_empty_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_module.md
WRITE_MODULE -- requirements
Module: write_module

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: BRAM data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: BRAM address width in bits.
REQ-003 SHALL have parameter RESULT_ADDR, default 32'hB000_1000: BRAM base byte address for results.
REQ-004 SHALL have parameter PIXEL_SIZE, default 8: bits per stored output pixel.
REQ-005 SHALL have parameter RESULT_WIDTH, default 16: width of the signed filter result.
REQ-006 SHALL have parameter OUT_IMAGE_SIZE, default 676: output pixels per image.
REQ-007 SHALL have parameter TOT_NUM_IMAGES, default 2: images per batch.
REQ-008 SHALL have ports: clk in 1, system clock; reset in 1, async active-high reset.
REQ-009 SHALL have ports: write_result in 1, PS start level (rising edge arms); result in RESULT_WIDTH, signed filter output; result_valid in 1, result qualifier.
REQ-010 SHALL have ports: bram_addr out ADDR_WIDTH; bram_wrdata out DATA_WIDTH; bram_en out 1; bram_we out 4, byte enables.
REQ-011 SHALL have ports: busy out 1, batch in progress; done out 1, one-cycle batch-complete pulse; overrun out 1, sticky error.
REQ-012 SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-013 SHALL implement states idle, collecting, finishing.
REQ-014 idle: on write_result==1 with previous-cycle write_result==0, SHALL load write pointer with RESULT_ADDR, clear counters, go to collecting.
REQ-015 result_valid in idle SHALL be ignored and SHALL set overrun; overrun clears only on reset or the next arming edge.
REQ-016 collecting: each cycle with result_valid==1 SHALL accept exactly one pixel; busy==1 in collecting and finishing.
REQ-017 Pixels SHALL pack big-endian: byte index 0 -> bits [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-018 On acceptance of byte index 3, the next cycle SHALL assert bram_en=1, bram_we=4'hF, bram_wrdata=packed word, bram_addr=write pointer; pointer then += 4.
REQ-019 Write SHALL overlap collection: a pixel accepted in the write cycle SHALL enter byte index 0 of the next word; no stall, no pixel loss at one pixel per cycle.
REQ-020 On acceptance of the last pixel of an image (count == OUT_IMAGE_SIZE-1) with byte index <3, SHALL issue a partial write next cycle: unused bytes 0, bram_we enables only filled bytes (e.g., 2 bytes -> 4'hC); pointer += 4; byte index resets to 0.
REQ-021 Each image SHALL start word-aligned at RESULT_ADDR + k*4*ceil(OUT_IMAGE_SIZE/4).
REQ-022 After the last pixel of image TOT_NUM_IMAGES-1, SHALL go to finishing; result_valid there SHALL be ignored and set overrun.
REQ-023 finishing: SHALL wait for the final write cycle to complete, then pulse done=1 for exactly one cycle and return to idle.
REQ-024 Arming edges outside idle SHALL be ignored.
REQ-025 bram_en and bram_we SHALL be 0 in every cycle without a write.

Reset
REQ-026 On reset: state idle; bram_addr, bram_wrdata, bram_we, bram_en, busy, done, overrun, all counters and previous-write_result register = 0.
REQ-027 Reset mid-batch SHALL abort immediately; the partial word SHALL be discarded, not written.

Configuration
REQ-028 Macro WRITE_MODULE_SATURATE_EN defined: stored pixel = 0 if result<0, 2^PIXEL_SIZE-1 if result>2^PIXEL_SIZE-1, else result.
REQ-029 Macro WRITE_MODULE_SATURATE_EN undefined: stored pixel = result[PIXEL_SIZE-1:0] (truncation).

Structure
REQ-030 State enum typedef, BRAM byte-enable width and base-address constants SHALL live in shared package comm_pkg.
REQ-031 Saturation/truncation plus byte packing SHALL be one sub-module, result_packer.

Verification
REQ-032 Arm, 676 consecutive valid results 0..675 (saturate on) -> 169 writes at B000_1000..B000_12A0, first word 32'h00010203, pixels >255 stored FF.
REQ-033 OUT_IMAGE_SIZE=6, 2 images -> per image full write then partial bram_we=4'hC; image 1 at base+8; done pulse one cycle after last write.
REQ-034 Result -5 and 300: saturate on -> 00, FF; saturate off -> FB, 2C.
REQ-035 result_valid gapped every other cycle and continuous -> identical BRAM contents, no lost pixel.
REQ-036 result_valid while idle -> no write, overrun=1; next arming edge clears overrun.
REQ-037 Reset after 3 bytes of a word -> no write issued, all outputs 0, re-arm restarts at RESULT_ADDR.
